// File: rtl/alu32_exec_stage.sv
// rtl/alu32_exec_stage.sv - 32-bit ALU execute stage with iterative shifter and valid/ready handshake
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake (op_sel, a, b sampled on accept)
//   op_sel                one-hot op: [0]AND [1]OR [2]ADD [3]SUB [4]XOR [5]SLT [6]SLL [7]SRL
//   a, b                  operands; b[CNT_W-1:0] is the shift amount
//   out_valid / out_ready result handshake
//   result                registered result
//   zero, carry, overflow registered flags
//   op_err                op_sel was not exactly one-hot
module alu32_exec_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             op_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             shift_right;

    logic             one_hot;
    logic             is_shift;
    logic             accept;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             alu_v;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign one_hot  = (op_sel != 8'h00) && ((op_sel & (op_sel - 8'h01)) == 8'h00);
    assign is_shift = one_hot && (op_sel[6] || op_sel[7]);

    // SUB shares the adder as a + ~b + 1 so carry means "no borrow".
    assign is_sub = op_sel[3];
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        if (one_hot) begin
            if (op_sel[0]) alu_r = a & b;
            if (op_sel[1]) alu_r = a | b;
            if (op_sel[4]) alu_r = a ^ b;
            if (op_sel[5]) alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            if (op_sel[2]) begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            if (op_sel[3]) begin
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = is_shift ? SHIFT : DONE;
            SHIFT:   if (cnt == '0) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            cnt         <= '0;
            shift_right <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            op_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_shift) begin
                            shreg       <= a;
                            cnt         <= b[CNT_W-1:0];
                            shift_right <= op_sel[7];
                        end else begin
                            // A non-one-hot op_sel leaves alu_r at 0, so zero comes out 1.
                            result   <= alu_r;
                            zero     <= (alu_r == '0);
                            carry    <= alu_c;
                            overflow <= alu_v;
                            op_err   <= !one_hot;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shreg <= shift_right ? (shreg >> 1) : (shreg << 1);
                        cnt   <= cnt - CNT_W'(1);
                    end else begin
                        result   <= shreg;
                        zero     <= (shreg == '0);
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        op_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_exec_stage.sv
// tb/tb_alu32_exec_stage.sv - self-checking bench for alu32_exec_stage
module tb_alu32_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op_sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        op_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu32_exec_stage #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry),
        .overflow(overflow), .op_err(op_err)
    );

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge, then measure latency: 1 means out_valid
    // is visible right after the accept edge.
    task automatic run_vec(input vec_t v);
        int n;
        int lat;
        logic ready_seen;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({v.name, " in_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op_sel   = v.op;
        a        = v.va;
        b        = v.vb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~v.va;
        b        = ~v.vb;
        op_sel   = 8'h04;
        lat = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'(v.lat));
        check({v.name, " busy in_ready"}, {31'b0, ready_seen}, 32'd0);
        check({v.name, " result"}, result, v.r);
        check({v.name, " flags z/c/v/e"}, {28'b0, zero, carry, overflow, op_err},
              {28'b0, v.z, v.c, v.v, v.e});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({v.name, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held;
        logic        stable;
        logic        busy_ready;
        logic        any_valid;

        vecs[0]  = '{"add_wrap", 8'h04, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1, 0, 0, 1};
        vecs[1]  = '{"add_ovf", 8'h04, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1, 0, 1};
        vecs[2]  = '{"sub_ovf", 8'h08, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 1, 0, 1};
        vecs[3]  = '{"sub_borrow", 8'h08, 32'h5, 32'h7, 32'hFFFF_FFFE, 0, 0, 0, 0, 1};
        vecs[4]  = '{"slt_neg", 8'h20, 32'hFFFF_FFFF, 32'h0, 32'h1, 0, 0, 0, 0, 1};
        vecs[5]  = '{"sll_31", 8'h40, 32'h1, 32'd31, 32'h8000_0000, 0, 0, 0, 0, 33};
        vecs[6]  = '{"srl_0", 8'h80, 32'h8000_0000, 32'h0, 32'h8000_0000, 0, 0, 0, 0, 2};
        vecs[7]  = '{"srl_hi_ignored", 8'h80, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 0, 0, 0, 0, 6};
        vecs[8]  = '{"err_zero", 8'h00, 32'h1234_5678, 32'h1, 32'h0, 1, 0, 0, 1, 1};
        vecs[9]  = '{"err_multi", 8'h0C, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0, 1, 1};
        vecs[10] = '{"and_after_err", 8'h01, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0, 1};
        vecs[11] = '{"xor_zero", 8'h10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1, 0, 0, 0, 1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_sel = 8'h00;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", {31'b0, in_ready}, 32'd0);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {28'b0, zero, carry, overflow, op_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: XOR result held while out_ready low and a new request waits.
        in_valid = 1'b1;
        op_sel = 8'h10;
        a = 32'h0F0F_0F0F;
        b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        op_sel = 8'h04;
        a = 32'h1;
        b = 32'h1;
        held = result;
        check("bp result", held, 32'hF0F0_F0F0);
        stable = 1'b1;
        busy_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (result !== held || !out_valid || zero || carry || overflow || op_err) stable = 1'b0;
            if (in_ready) busy_ready = 1'b1;
        end
        check("bp stable", {31'b0, stable}, 32'd1);
        check("bp in_ready low", {31'b0, busy_ready}, 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp idle out_valid", {31'b0, out_valid}, 32'd0);
        check("bp idle in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        run_vec('{"add_after_bp", 8'h04, 32'h1, 32'h1, 32'h2, 0, 0, 0, 0, 1});

        // Reset in the middle of a 20-bit shift.
        in_valid = 1'b1;
        op_sel = 8'h40;
        a = 32'h1;
        b = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort outputs", {result[27:0], out_valid, zero, carry, overflow} | {31'b0, op_err}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort in_ready", {31'b0, in_ready}, 32'd0);
        any_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) any_valid = 1'b1;
        end
        check("abort no out_valid", {31'b0, any_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post rst in_ready", {31'b0, in_ready}, 32'd1);
        run_vec('{"or_after_rst", 8'h02, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 0, 0, 0, 0, 1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
